// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed, XOR-checksummed big-endian byte stream into instruction memory words and releases CPU reset once verified
// ports: clk/rst (async active-low) | start | in_data/in_valid/in_ready byte stream
//        wr_en/wr_addr/wr_data imem write port | cpu_rst_n | busy/done/err status
module imem_loader #(
  parameter int               ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int               MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR} state_t;
  state_t state, nxt;
  logic [15:0] len, word_cnt, n;
  logic [23:0] shreg;
  logic [7:0]  xacc;
  logic [1:0]  byte_cnt;
  logic        xfer, idle_like, go;
  assign n         = {len[15:8], in_data};
  assign idle_like = state inside {IDLE, DONE, ERR};
  assign go        = idle_like & start;
  assign xfer      = in_valid & in_ready;
  always_comb begin
    nxt       = state;
    in_ready  = state inside {LEN_HI, LEN_LO, DATA, CHK};
    wr_en     = state == WRITE;
    busy      = !idle_like;
    done      = state == DONE;
    err       = state == ERR;
    cpu_rst_n = state == DONE;
    case (state)
      IDLE, DONE, ERR: nxt = start ? LEN_HI : state;
      LEN_HI:          nxt = xfer ? LEN_LO : state;
      LEN_LO:          nxt = !xfer ? state : 32'(n) > MAX_WORDS ? ERR : n == 16'd0 ? CHK : DATA;
      DATA:            nxt = xfer && byte_cnt == 2'd3 ? WRITE : state;
      WRITE:           nxt = word_cnt + 16'd1 == len ? CHK : DATA;
      CHK:             nxt = !xfer ? state : xacc == in_data ? DONE : ERR;
      default:         nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      len      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      xacc     <= '0;
      shreg    <= '0;
      wr_addr  <= BASE_ADDR;
      wr_data  <= '0;
    end else begin
      state <= nxt;
      if (go) begin
        word_cnt <= '0;
        byte_cnt <= '0;
        xacc     <= '0;
      end
      // the checksum byte itself never enters the running XOR
      if (xfer && state != CHK) xacc <= xacc ^ in_data;
      if (xfer && state == LEN_HI) len[15:8] <= in_data;
      if (xfer && state == LEN_LO) len[7:0] <= in_data;
      if (xfer && state == DATA) begin
        shreg    <= {shreg[15:0], in_data};
        byte_cnt <= byte_cnt + 2'd1;
        // latch the write beat early so address/data are valid throughout WRITE
        if (byte_cnt == 2'd3) begin
          wr_addr <= BASE_ADDR + ADDR_W'(word_cnt);
          wr_data <= {shreg, in_data};
        end
      end
      if (state == WRITE) begin
        word_cnt <= word_cnt + 16'd1;
        byte_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed-vector bench for imem_loader with a write log and hand-computed expectations
module tb_imem_loader;
  logic        clk = 0, rst = 0, start = 0, in_valid = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, wr_en, cpu_rst_n, busy, done, err;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  int          vec = 0, bad = 0, rdy_in_write = 0;
  logic [15:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  bq[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_en) begin
    wa.push_back(wr_addr);
    wd.push_back(wr_data);
    if (in_ready) rdy_in_write++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic feed(input bit gaps);
    foreach (bq[i]) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send(bq[i]);
    end
  endtask

  task automatic new_load();
    wa.delete();
    wd.delete();
    pulse_start();
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic c);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_cpurst"}, 32'(cpu_rst_n), 32'(c));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 0);
    check("rst_wren", 32'(wr_en), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_data", wr_data, 0);
    check("rst_busy", 32'(busy), 0);
    check_status("rst", 0, 0, 0);
    rst = 1;
    @(negedge clk);

    new_load();
    check("go_busy", 32'(busy), 1);
    bq = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h2A, 8'h0A};
    feed(0);
    check("norm_nwr", 32'(wa.size()), 2);
    check("norm_a0", 32'(wa[0]), 32'h0000);
    check("norm_d0", wd[0], 32'hDEADBEEF);
    check("norm_a1", 32'(wa[1]), 32'h0001);
    check("norm_d1", wd[1], 32'h0000002A);
    check_status("norm", 1, 0, 1);
    check("norm_busy", 32'(busy), 0);
    check("norm_hold", wr_data, 32'h0000002A);

    new_load();
    bq = '{8'h00, 8'h00, 8'h00};
    feed(0);
    check("zero_nwr", 32'(wa.size()), 0);
    check_status("zero", 1, 0, 1);

    new_load();
    bq = '{8'h00, 8'h00, 8'h01};
    feed(0);
    check("zbad_nwr", 32'(wa.size()), 0);
    check_status("zbad", 0, 1, 0);

    new_load();
    bq = '{8'h04, 8'h01};
    feed(0);
    check_status("over", 0, 1, 0);
    check("over_ready", 32'(in_ready), 0);
    in_valid = 1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    in_valid = 0;
    check("over_ready2", 32'(in_ready), 0);
    check("over_nwr", 32'(wa.size()), 0);

    new_load();
    rdy_in_write = 0;
    bq = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
           8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCF};
    feed(1);
    check("bp_nwr", 32'(wa.size()), 3);
    check("bp_d0", wd[0], 32'h11223344);
    check("bp_d1", wd[1], 32'h55667788);
    check("bp_a2", 32'(wa[2]), 32'h0002);
    check("bp_d2", wd[2], 32'h99AABBCC);
    check("bp_rdy_wr", 32'(rdy_in_write), 0);
    check_status("bp", 1, 0, 1);

    new_load();
    bq = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    feed(0);
    check("mid_busy_pre", 32'(busy), 1);
    rst = 0;
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_ready", 32'(in_ready), 0);
    check("mid_addr", 32'(wr_addr), 0);
    check("mid_data", wr_data, 0);
    check_status("mid", 0, 0, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    new_load();
    bq = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hC8};
    feed(0);
    check("one_nwr", 32'(wa.size()), 1);
    check("one_a0", 32'(wa[0]), 32'h0000);
    check("one_d0", wd[0], 32'hCAFEF00D);
    check_status("one", 1, 0, 1);

    new_load();
    check_status("re", 0, 0, 0);
    bq = '{8'h00, 8'h01, 8'h00, 8'h00};
    feed(0);
    pulse_start();
    check("ign_busy", 32'(busy), 1);
    bq = '{8'h00, 8'h07, 8'h06};
    feed(0);
    check("re_nwr", 32'(wa.size()), 1);
    check("re_a0", 32'(wa[0]), 32'h0000);
    check("re_d0", wd[0], 32'h00000007);
    check_status("re_end", 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
